// File: rtl/sdram_p2_queue.sv
// sdram_p2_queue
// Client-side request queue for SDRAM controller port 2. Requests are
// buffered in a small circular FIFO and issued one at a time on the p2_*
// handshake. The controller signals completion by toggling p2_ack.
// The head entry stays in the FIFO until its access completes, so level
// counts the in-flight access too.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   client request handshake
//   req_we/addr/din/ds    request payload (word address, write data, strobes)
//   rsp_valid/rsp_data    one-cycle read-data strobe and data
//   p2_cs/we/addr/din/ds  controller request (held for the whole access)
//   p2_ack, p2_dout       completion toggle and read data from controller
//   level, busy           FIFO occupancy, activity flag
//   timeout_err           sticky timeout flag (timeout build only)
//
// Build option
//   SDRAM_P2Q_TIMEOUT_EN  adds a WAIT-cycle counter; an access that sees no
//                         ack within TIMEOUT cycles is abandoned, reads
//                         return 16'hFFFF and timeout_err is set.
//
// Parameters
//   DEPTH    FIFO depth, power of two in 2..16
//   TIMEOUT  maximum WAIT cycles (>= 1), timeout build only
//
// state | meaning
// IDLE  | no access outstanding; loads the FIFO head when level != 0
// WAIT  | access presented on p2_*, waiting for p2_ack to differ from ack_ref
// GAP   | one cs-low cycle between accesses

module sdram_p2_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [21:0]              req_addr,
  input  logic [15:0]              req_din,
  input  logic [1:0]               req_ds,
  output logic                     rsp_valid,
  output logic [15:0]              rsp_data,
  output logic                     p2_cs,
  output logic                     p2_we,
  output logic [21:0]              p2_addr,
  output logic [15:0]              p2_din,
  output logic [1:0]               p2_ds,
  input  logic                     p2_ack,
  input  logic [15:0]              p2_dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
`ifdef SDRAM_P2Q_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 1 + 22 + 16 + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ack_ref_q;
  logic            p2_cs_q;
  logic            p2_we_q;
  logic [21:0]     p2_addr_q;
  logic [15:0]     p2_din_q;
  logic [1:0]      p2_ds_q;
  logic            rsp_valid_q;
  logic [15:0]     rsp_data_q;
  logic [EW-1:0]   head;
  logic            push;
  logic            pop;
  logic            ack_seen;

`ifdef SDRAM_P2Q_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   cnt_q;
  logic            to_hit;
  logic            timeout_err_q;
`else
  // TIMEOUT has no effect in this build; keep it referenced.
  localparam logic [31:0] TIMEOUT_VEC = TIMEOUT;
  logic            unused_timeout;
  assign unused_timeout = ^TIMEOUT_VEC;
`endif

  assign req_ready = (level_q != LW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign head      = mem_q[rd_ptr_q];
  assign ack_seen  = (state_q == ST_WAIT) && (p2_ack != ack_ref_q);

  // A completed (or abandoned) access is what frees its FIFO slot.
  always_comb begin
`ifdef SDRAM_P2Q_TIMEOUT_EN
    to_hit = (state_q == ST_WAIT) && !ack_seen && (cnt_q == TW'(TIMEOUT - 1));
    pop    = ack_seen || to_hit;
`else
    pop    = ack_seen;
`endif
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_we, req_addr, req_din, req_ds};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ack_ref_q   <= 1'b0;
      p2_cs_q     <= 1'b0;
      p2_we_q     <= 1'b0;
      p2_addr_q   <= '0;
      p2_din_q    <= '0;
      p2_ds_q     <= 2'b11;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef SDRAM_P2Q_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (level_q != '0) begin
            {p2_we_q, p2_addr_q, p2_din_q, p2_ds_q} <= head;
            // The ack line idles at whatever parity the last access left.
            ack_ref_q <= p2_ack;
            p2_cs_q   <= 1'b1;
            state_q   <= ST_WAIT;
`ifdef SDRAM_P2Q_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (ack_seen) begin
            p2_cs_q <= 1'b0;
            state_q <= ST_GAP;
            if (!p2_we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= p2_dout;
            end
          end
`ifdef SDRAM_P2Q_TIMEOUT_EN
          else if (to_hit) begin
            p2_cs_q       <= 1'b0;
            state_q       <= ST_GAP;
            timeout_err_q <= 1'b1;
            if (!p2_we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= 16'hFFFF;
            end
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
`endif
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign p2_cs     = p2_cs_q;
  assign p2_we     = p2_we_q;
  assign p2_addr   = p2_addr_q;
  assign p2_din    = p2_din_q;
  assign p2_ds     = p2_ds_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign level     = level_q;
  assign busy      = (state_q != ST_IDLE) || (level_q != '0);
`ifdef SDRAM_P2Q_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: doc/sdram_p2_queue.md
SDRAM_P2_QUEUE -- requirements
Module: sdram_p2_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO depth; must be a power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for p2_ack; used only with the timeout feature.
REQ-003 SHALL have port clk  in  1  SDRAM controller clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1, req_addr in 22 (word address), req_din in 16, req_ds in 2 (upper/lower strobe); together they form the client request channel.
REQ-006 SHALL have ports rsp_valid out 1 (one-cycle read-data strobe) and rsp_data out 16 (read data).
REQ-007 SHALL have controller-side ports: p2_cs out 1, p2_we out 1, p2_addr out 22, p2_din out 16, p2_ds out 2, p2_ack in 1 (toggle per completed access), p2_dout in 16.
REQ-008 SHALL have status ports: level out log2(DEPTH)+1 (FIFO occupancy), busy out 1 (access outstanding or FIFO non-empty).

Function
REQ-009 SHALL accept a request on any clk edge where req_valid and req_ready are both high; req_ready = (level != DEPTH), taken from registered state.
REQ-010 SHALL store {we, addr, din, ds} per entry in a circular FIFO; read and write pointers wrap modulo DEPTH.
REQ-011 SHALL implement three states: IDLE, WAIT, GAP.
REQ-012 In IDLE with level != 0, SHALL load the head entry into p2_we/p2_addr/p2_din/p2_ds, record ack_ref = p2_ack, set p2_cs = 1 and enter WAIT; all four outputs SHALL appear in the same cycle.
REQ-013 In WAIT, p2_cs and all p2_* request outputs SHALL hold stable until p2_ack != ack_ref.
REQ-014 On the cycle p2_ack != ack_ref is sampled in WAIT, the block SHALL clear p2_cs, pop the head and enter GAP; if p2_we = 0 it SHALL also register p2_dout into rsp_data and pulse rsp_valid for exactly one cycle on the next edge.
REQ-015 Writes SHALL produce no rsp_valid.
REQ-016 GAP SHALL last exactly one cycle with p2_cs = 0, then return to IDLE, so every access is separated by at least one cs-low cycle.
REQ-017 Minimum request-to-cs latency from an empty FIFO SHALL be 2 cycles: push, then IDLE load.
REQ-018 A simultaneous push and pop SHALL leave level unchanged; a push while full SHALL be impossible because req_ready = 0.
REQ-019 busy SHALL be (state != IDLE) or (level != 0).
REQ-020 Responses SHALL return in request order; at most one access is outstanding.

Reset
REQ-021 While reset_n = 0 at a clk edge: state = IDLE, pointers = 0, level = 0, p2_cs = 0, p2_we = 0, p2_addr = 0, p2_din = 0, p2_ds = 2'b11, rsp_valid = 0, rsp_data = 0, timeout_err = 0.
REQ-022 Reset asserted mid-access SHALL discard the FIFO and the outstanding access without producing rsp_valid; ack_ref SHALL be re-captured at the next IDLE load.

Configuration
REQ-023 Macro SDRAM_P2Q_TIMEOUT_EN, when defined, SHALL add a cycle counter that is cleared on entry to WAIT and incremented each cycle in WAIT.
REQ-024 With SDRAM_P2Q_TIMEOUT_EN defined: if the counter reaches TIMEOUT before an ack, the block SHALL drop p2_cs, pop the entry, pulse rsp_valid with rsp_data = 16'hFFFF for reads, set the sticky output timeout_err (1 bit) and enter GAP.
REQ-025 Without SDRAM_P2Q_TIMEOUT_EN, the timeout_err port and the counter SHALL NOT exist, and WAIT SHALL wait for the ack indefinitely.

Verification
REQ-026 Single read: push we=0, addr=22'h012345, ds=2'b00; model toggles p2_ack 8 cycles after cs with p2_dout=16'hBEEF -> p2_cs high 2 cycles after push and held; rsp_valid pulses once with rsp_data=16'hBEEF; p2_cs low for exactly one GAP cycle.
REQ-027 Fill: push 5 requests back-to-back with DEPTH=4 and ack withheld -> req_ready low after the 4th accept, and level reaches 4 after the model's IDLE load pops nothing; the 5th request is held until the first ack.
REQ-028 Mixed order: write 16'h1234 to addr 22'h000010, then read addr 22'h000010 with the model returning the written data -> exactly one rsp_valid with rsp_data=16'h1234; p2_we=1 only during the first access.
REQ-029 Wrap: 10 sequential reads of addresses 0..9 with returned data = address -> rsp_data sequence 0..9 in order, pointers wrap twice, level returns to 0 and busy goes low.
REQ-030 Reset mid-WAIT: assert reset_n=0 for 1 cycle while p2_cs=1 -> next cycle p2_cs=0, level=0, no rsp_valid; a later ack toggle is ignored.
REQ-031 Timeout (SDRAM_P2Q_TIMEOUT_EN defined, TIMEOUT=16): read with ack never toggled -> after 16 WAIT cycles p2_cs=0, rsp_data=16'hFFFF with rsp_valid, timeout_err=1 and it stays 1.
